// File: rtl/encoder_pkg.sv
// -----------------------------------------------------------------------------
// encoder_pkg
//   Shared widths, index type and constants for the 8-to-3 priority encoder.
//   Optional feature macro used by the encoder files: ENC_ONEHOT_CHK_EN.
// -----------------------------------------------------------------------------
package encoder_pkg;

    localparam int ENC_IN_W  = 8;
    localparam int ENC_OUT_W = 3;

    typedef logic [ENC_OUT_W-1:0] enc_idx_t;

    // Index reported when no request line is high (indistinguishable from d0
    // without looking at valid).
    localparam enc_idx_t ENC_IDX_NONE = 3'b000;

endpackage : encoder_pkg

// File: rtl/encoder_8_3_comb.sv
// -----------------------------------------------------------------------------
// encoder_8_3_comb
//   Purely combinational priority encoder: highest set bit of i_d wins.
//   Optional feature macro: ENC_ONEHOT_CHK_EN (adds o_multi).
// Ports
//   i_d     in  [7:0]  request vector, bit N = request line N
//   o_idx   out [2:0]  index of the highest set bit (ENC_IDX_NONE if none)
//   o_any   out 1      at least one bit of i_d is set
//   o_multi out 1      more than one bit set (only with ENC_ONEHOT_CHK_EN)
// -----------------------------------------------------------------------------
module encoder_8_3_comb
    import encoder_pkg::*;
(
    input  logic [ENC_IN_W-1:0] i_d,
    output enc_idx_t            o_idx,
    output logic                o_any
`ifdef ENC_ONEHOT_CHK_EN
    ,
    output logic                o_multi
`endif
);

    // Ascending scan: later (higher) set bits overwrite earlier ones, which
    // gives highest-index priority.
    always_comb begin
        o_idx = ENC_IDX_NONE;
        for (int i = 0; i < ENC_IN_W; i++) begin
            if (i_d[i]) begin
                o_idx = enc_idx_t'(i);
            end
        end
    end

    assign o_any = |i_d;

`ifdef ENC_ONEHOT_CHK_EN
    logic [ENC_IN_W-1:0] w_low_cleared;

    // Clearing the lowest set bit leaves something only if two or more bits
    // were set, i.e. popcount > 1.
    assign w_low_cleared = i_d & (i_d - {{(ENC_IN_W-1){1'b0}}, 1'b1});
    assign o_multi       = |w_low_cleared;
`endif

endmodule : encoder_8_3_comb

// File: rtl/encoder_8_3.sv
// -----------------------------------------------------------------------------
// encoder_8_3
//   8-to-3 priority encoder with registered outputs (1-cycle latency).
//   Outputs update every cycle; there is no enable and no handshake.
//   Optional feature macro: ENC_ONEHOT_CHK_EN (adds err output).
// Ports
//   clk     in   1  rising-edge clock
//   rst_n   in   1  asynchronous active-low reset, clears all outputs
//   d0..d7  in   1  request lines, dN high selects index N (synchronous to clk)
//   a,b,c   out  1  registered index {a,b,c}, a = MSB
//   valid   out  1  registered "some request line was high"
//   err     out  1  registered "more than one line was high"
//                   (only with ENC_ONEHOT_CHK_EN)
// -----------------------------------------------------------------------------
module encoder_8_3
    import encoder_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic d4,
    input  logic d5,
    input  logic d6,
    input  logic d7,
    output logic a,
    output logic b,
    output logic c,
    output logic valid
`ifdef ENC_ONEHOT_CHK_EN
    ,
    output logic err
`endif
);

    logic [ENC_IN_W-1:0] w_d;
    enc_idx_t            w_idx;
    logic                w_any;

    enc_idx_t            r_idx;
    logic                r_valid;

    assign w_d = {d7, d6, d5, d4, d3, d2, d1, d0};

`ifdef ENC_ONEHOT_CHK_EN
    logic w_multi;
    logic r_err;

    encoder_8_3_comb u_comb (
        .i_d     (w_d),
        .o_idx   (w_idx),
        .o_any   (w_any),
        .o_multi (w_multi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_multi;
        end
    end

    assign err = r_err;
`else
    encoder_8_3_comb u_comb (
        .i_d   (w_d),
        .o_idx (w_idx),
        .o_any (w_any)
    );
`endif

    // No stale state: every edge with rst_n high reloads from the current
    // inputs, including the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= ENC_IDX_NONE;
            r_valid <= 1'b0;
        end else begin
            r_idx   <= w_idx;
            r_valid <= w_any;
        end
    end

    assign a     = r_idx[2];
    assign b     = r_idx[1];
    assign c     = r_idx[0];
    assign valid = r_valid;

endmodule : encoder_8_3

// File: tb/tb_encoder_8_3.sv
// -----------------------------------------------------------------------------
// tb_encoder_8_3
//   Directed self-checking bench for encoder_8_3. Honours ENC_ONEHOT_CHK_EN
//   (connects and checks err only when the macro is defined).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_encoder_8_3;

    logic       clk;
    logic       rst_n;
    logic [7:0] tb_d;
    logic       a;
    logic       b;
    logic       c;
    logic       valid;
`ifdef ENC_ONEHOT_CHK_EN
    logic       err;
`endif

    int n_vectors;
    int n_miscompares;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;   // rising edges at 5, 15, 25, ...

    encoder_8_3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d0    (tb_d[0]),
        .d1    (tb_d[1]),
        .d2    (tb_d[2]),
        .d3    (tb_d[3]),
        .d4    (tb_d[4]),
        .d5    (tb_d[5]),
        .d6    (tb_d[6]),
        .d7    (tb_d[7]),
        .a     (a),
        .b     (b),
        .c     (c),
        .valid (valid)
`ifdef ENC_ONEHOT_CHK_EN
        ,
        .err   (err)
`endif
    );

    // ---------------- driver helpers ----------------
    // Advance to 1 ns after the next rising edge, away from the edge itself.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [2:0] exp_abc,
                         input logic exp_valid, input logic exp_err);
        logic [2:0] obs_abc;
        obs_abc = {a, b, c};
        n_vectors++;
        assert (obs_abc === exp_abc) else begin
            n_miscompares++;
            $error("FAIL %s abc: observed %b expected %b", tag, obs_abc, exp_abc);
        end
        n_vectors++;
        assert (valid === exp_valid) else begin
            n_miscompares++;
            $error("FAIL %s valid: observed %b expected %b", tag, valid, exp_valid);
        end
`ifdef ENC_ONEHOT_CHK_EN
        n_vectors++;
        assert (err === exp_err) else begin
            n_miscompares++;
            $error("FAIL %s err: observed %b expected %b", tag, err, exp_err);
        end
`else
        if (exp_err === 1'bx) begin
            $display("note: %s err expectation unknown", tag);
        end
`endif
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_vectors     = 0;
        n_miscompares = 0;

        // Reset held with d7 high: outputs stay 0, between and across edges.
        rst_n = 1'b0;
        tb_d  = 8'h80;
        #3;
        check("reset_before_clk", 3'b000, 1'b0, 1'b0);
        tick();
        check("reset_after_edge1", 3'b000, 1'b0, 1'b0);
        tick();
        check("reset_after_edge2", 3'b000, 1'b0, 1'b0);
        #3;
        check("reset_between_edges", 3'b000, 1'b0, 1'b0);

        // Release reset away from the edge; first edge encodes d7.
        rst_n = 1'b1;
        #1;
        check("release_before_edge", 3'b000, 1'b0, 1'b0);
        tick();
        check("release_first_edge", 3'b111, 1'b1, 1'b0);

        // One-hot sweep d0..d7.
        tb_d = 8'h01; tick(); check("onehot_d0", 3'b000, 1'b1, 1'b0);
        tb_d = 8'h02; tick(); check("onehot_d1", 3'b001, 1'b1, 1'b0);
        tb_d = 8'h04; tick(); check("onehot_d2", 3'b010, 1'b1, 1'b0);
        tb_d = 8'h08; tick(); check("onehot_d3", 3'b011, 1'b1, 1'b0);
        tb_d = 8'h10; tick(); check("onehot_d4", 3'b100, 1'b1, 1'b0);
        tb_d = 8'h20; tick(); check("onehot_d5", 3'b101, 1'b1, 1'b0);
        tb_d = 8'h40; tick(); check("onehot_d6", 3'b110, 1'b1, 1'b0);
        tb_d = 8'h80; tick(); check("onehot_d7", 3'b111, 1'b1, 1'b0);

        // All zero: index 000 with valid low.
        tb_d = 8'h00; tick(); check("all_zero", 3'b000, 1'b0, 1'b0);

        // Latency: output holds old value until the edge.
        tb_d = 8'h08;
        #2;
        check("latency_hold", 3'b000, 1'b0, 1'b0);
        tick(); check("latency_update", 3'b011, 1'b1, 1'b0);

        // Priority cases.
        tb_d = 8'h24; tick(); check("prio_d2_d5", 3'b101, 1'b1, 1'b1);
        tb_d = 8'h81; tick(); check("prio_d0_d7", 3'b111, 1'b1, 1'b1);
        tb_d = 8'hFF; tick(); check("prio_all", 3'b111, 1'b1, 1'b1);
        tb_d = 8'h0A; tick(); check("prio_d1_d3", 3'b011, 1'b1, 1'b1);
        tb_d = 8'h03; tick(); check("prio_d0_d1", 3'b001, 1'b1, 1'b1);
        tb_d = 8'h70; tick(); check("prio_d4_d5_d6", 3'b110, 1'b1, 1'b1);

        // Async reset mid-run while abc = 110.
        tb_d = 8'h40; tick(); check("pre_async_d6", 3'b110, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_drop", 3'b000, 1'b0, 1'b0);
        tick(); check("async_held", 3'b000, 1'b0, 1'b0);

        // Release with new inputs: no stale d6 result.
        rst_n = 1'b1;
        tb_d  = 8'h10;
        tick(); check("post_async_d4", 3'b100, 1'b1, 1'b0);
        tb_d = 8'h00; tick(); check("post_async_zero", 3'b000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_encoder_8_3
